// File: rtl/id_stage.sv
// Decode stage: 32-entry register file written from WB, main control decode, sign extension, ID/EX latch.
// Optional macro ID_WB_BYPASS_EN forwards the WB write data onto the read ports during the same cycle.
module id_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id_npc,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [15:0]       id_instr,
    input  logic [4:0]        instr_2016,
    input  logic [4:0]        instr_1511,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic [1:0]        wb_ctlout,
    output logic [2:0]        m_ctlout,
    output logic [3:0]        ex_ctlout,
    output logic [31:0]       ex_npc,
    output logic [DATA_W-1:0] readdat1,
    output logic [DATA_W-1:0] readdat2,
    output logic [DATA_W-1:0] sign_ext,
    output logic [4:0]        ex_instr_2016,
    output logic [4:0]        ex_instr_1511
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [DATA_W-1:0] rf_q [REG_NUM];

    logic              rf_we;
    logic [1:0]        wb_ctl_d, wb_ctl_q;
    logic [2:0]        m_ctl_d, m_ctl_q;
    logic [3:0]        ex_ctl_d, ex_ctl_q;
    logic [DATA_W-1:0] rd1_d, rd2_d;
    logic [DATA_W-1:0] rd1_q, rd2_q;
    logic [DATA_W-1:0] sext_d, sext_q;
    logic [31:0]       npc_q;
    logic [4:0]        i2016_q, i1511_q;

    // r0 is never stored, so it always reads zero.
    assign rf_we = wb_regwrite && (wb_write_reg != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[wb_write_reg] <= wb_write_data;
        end
    end

    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs != 5'd0) rd1_d = rf_q[rs];
        if (rt != 5'd0) rd2_d = rf_q[rt];
`ifdef ID_WB_BYPASS_EN
        if (rf_we && (wb_write_reg == rs)) rd1_d = wb_write_data;
        if (rf_we && (wb_write_reg == rt)) rd2_d = wb_write_data;
`endif
    end

    // Control words: wb={regwrite,memtoreg}, m={branch,memread,memwrite}, ex={regdst,aluop,alusrc}.
    always_comb begin
        wb_ctl_d = 2'b00;
        m_ctl_d  = 3'b000;
        ex_ctl_d = 4'b0000;
        case (opcode)
            OP_RTYPE: begin
                wb_ctl_d = 2'b10;
                ex_ctl_d = 4'b1100;
            end
            OP_LW: begin
                wb_ctl_d = 2'b11;
                m_ctl_d  = 3'b010;
                ex_ctl_d = 4'b0001;
            end
            OP_SW: begin
                m_ctl_d  = 3'b001;
                ex_ctl_d = 4'b0001;
            end
            OP_BEQ: begin
                m_ctl_d  = 3'b100;
                ex_ctl_d = 4'b0010;
            end
            default: begin
                wb_ctl_d = 2'b00;
                m_ctl_d  = 3'b000;
                ex_ctl_d = 4'b0000;
            end
        endcase
    end

    assign sext_d = {{(DATA_W-16){id_instr[15]}}, id_instr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ctl_q <= '0;
            m_ctl_q  <= '0;
            ex_ctl_q <= '0;
            npc_q    <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            sext_q   <= '0;
            i2016_q  <= '0;
            i1511_q  <= '0;
        end else begin
            wb_ctl_q <= wb_ctl_d;
            m_ctl_q  <= m_ctl_d;
            ex_ctl_q <= ex_ctl_d;
            npc_q    <= id_npc;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            sext_q   <= sext_d;
            i2016_q  <= instr_2016;
            i1511_q  <= instr_1511;
        end
    end

    assign wb_ctlout     = wb_ctl_q;
    assign m_ctlout      = m_ctl_q;
    assign ex_ctlout     = ex_ctl_q;
    assign ex_npc        = npc_q;
    assign readdat1      = rd1_q;
    assign readdat2      = rd2_q;
    assign sign_ext      = sext_q;
    assign ex_instr_2016 = i2016_q;
    assign ex_instr_1511 = i1511_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: decode table vectors, directed multi-cycle sequences, and random traffic
// against a register-file model; honours ID_WB_BYPASS_EN when defined.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] id_npc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt;
    logic [15:0] id_instr;
    logic [4:0]  instr_2016, instr_1511;
    logic        wb_regwrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [3:0]  ex_ctlout;
    logic [31:0] ex_npc, readdat1, readdat2, sign_ext;
    logic [4:0]  ex_instr_2016, ex_instr_1511;

    id_stage dut (
        .clk(clk), .reset(reset), .id_npc(id_npc), .opcode(opcode), .rs(rs), .rt(rt),
        .id_instr(id_instr), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .ex_ctlout(ex_ctlout), .ex_npc(ex_npc),
        .readdat1(readdat1), .readdat2(readdat2), .sign_ext(sign_ext),
        .ex_instr_2016(ex_instr_2016), .ex_instr_1511(ex_instr_1511)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] model_rf [32];

    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Control table from the ISA subset: {regwrite,memtoreg, branch,memread,memwrite, regdst,aluop,alusrc}
    function automatic logic [8:0] ref_ctl(input logic [5:0] op);
        case (op)
            6'b000000: return {2'b10, 3'b000, 1'b1, 2'b10, 1'b0};
            6'b100011: return {2'b11, 3'b010, 1'b0, 2'b00, 1'b1};
            6'b101011: return {2'b00, 3'b001, 1'b0, 2'b00, 1'b1};
            6'b000100: return {2'b00, 3'b100, 1'b0, 2'b01, 1'b0};
            default:   return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && wb_regwrite && wb_write_reg == a) return wb_write_data;
        return model_rf[a];
    endfunction

    task automatic clear_inputs();
        id_npc = '0; opcode = 6'b111111; rs = '0; rt = '0; id_instr = '0;
        instr_2016 = '0; instr_1511 = '0; wb_regwrite = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    endtask

    // Driver: computes the expected latch contents from current inputs, clocks once, compares,
    // then retires the WB write into the model.
    task automatic do_cycle();
        logic [8:0] c;
        c = ref_ctl(opcode);
        exp_q.push_back({23'd0, c});
        exp_q.push_back(id_npc);
        exp_q.push_back(ref_read(rs));
        exp_q.push_back(ref_read(rt));
        exp_q.push_back({{16{id_instr[15]}}, id_instr});
        exp_q.push_back({22'd0, instr_2016, instr_1511});
        @(posedge clk);
        #1;
        chk("ctl",       {23'd0, wb_ctlout, m_ctlout, ex_ctlout}, exp_q.pop_front());
        chk("ex_npc",    ex_npc,   exp_q.pop_front());
        chk("readdat1",  readdat1, exp_q.pop_front());
        chk("readdat2",  readdat2, exp_q.pop_front());
        chk("sign_ext",  sign_ext, exp_q.pop_front());
        chk("instr_fld", {22'd0, ex_instr_2016, ex_instr_1511}, exp_q.pop_front());
        if (wb_regwrite && wb_write_reg != 5'd0) model_rf[wb_write_reg] = wb_write_data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {23'd0, wb_ctlout, m_ctlout, ex_ctlout}, 32'd0);
        chk({tag, "_npc"}, ex_npc, 32'd0);
        chk({tag, "_rd1"}, readdat1, 32'd0);
        chk({tag, "_rd2"}, readdat2, 32'd0);
        chk({tag, "_sx"},  sign_ext, 32'd0);
        chk({tag, "_fld"}, {22'd0, ex_instr_2016, ex_instr_1511}, 32'd0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [15:0] imm;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] sx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{6'b000000, 16'h0000, 2'b10, 3'b000, 4'b1100, 32'h0000_0000};
        vecs[1] = '{6'b100011, 16'hFFFC, 2'b11, 3'b010, 4'b0001, 32'hFFFF_FFFC};
        vecs[2] = '{6'b101011, 16'h0010, 2'b00, 3'b001, 4'b0001, 32'h0000_0010};
        vecs[3] = '{6'b000100, 16'h8000, 2'b00, 3'b100, 4'b0010, 32'hFFFF_8000};
        vecs[4] = '{6'b111111, 16'h7FFF, 2'b00, 3'b000, 4'b0000, 32'h0000_7FFF};
        vecs[5] = '{6'b000010, 16'hFFFF, 2'b00, 3'b000, 4'b0000, 32'hFFFF_FFFF};
        vecs[6] = '{6'b100000, 16'h1234, 2'b00, 3'b000, 4'b0000, 32'h0000_1234};
        vecs[7] = '{6'b000101, 16'h8001, 2'b00, 3'b000, 4'b0000, 32'hFFFF_8001};

        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        clear_inputs();

        // power-on reset, with a WB write that must be ignored
        reset = 1'b1;
        #3;
        chk_all_zero("por");
        wb_regwrite = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk_all_zero("por_edge");
        #2;
        reset = 1'b0;
        clear_inputs();
        rs = 5'd3; opcode = 6'b000000;
        do_cycle();
        chk("por_rf_write_ignored", readdat1, 32'd0);

        // decode / sign extension table
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            opcode = vecs[i].op; id_instr = vecs[i].imm;
            do_cycle();
            chk($sformatf("vec%0d_wb", i), {30'd0, wb_ctlout}, {30'd0, vecs[i].wb});
            chk($sformatf("vec%0d_m", i),  {29'd0, m_ctlout},  {29'd0, vecs[i].m});
            chk($sformatf("vec%0d_ex", i), {28'd0, ex_ctlout}, {28'd0, vecs[i].ex});
            chk($sformatf("vec%0d_sx", i), sign_ext, vecs[i].sx);
        end

        // RF write then read of r8
        clear_inputs();
        wb_regwrite = 1'b1; wb_write_reg = 5'd8; wb_write_data = 32'h0000_00A5;
        do_cycle();
        clear_inputs();
        rs = 5'd8; opcode = 6'b000000;
        do_cycle();
        chk("r8_read", readdat1, 32'h0000_00A5);
        chk("r8_wbctl", {30'd0, wb_ctlout}, 32'd2);
        chk("r8_exctl", {28'd0, ex_ctlout}, 32'hC);

        // r0 protection
        clear_inputs();
        wb_regwrite = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'hFFFF_FFFF;
        do_cycle();
        clear_inputs();
        rs = 5'd0; rt = 5'd0;
        do_cycle();
        chk("r0_read1", readdat1, 32'd0);
        chk("r0_read2", readdat2, 32'd0);

        // same-cycle write/read hazard on r9, rs==rt
        clear_inputs();
        wb_regwrite = 1'b1; wb_write_reg = 5'd9; wb_write_data = 32'h11;
        do_cycle();
        clear_inputs();
        wb_regwrite = 1'b1; wb_write_reg = 5'd9; wb_write_data = 32'h22;
        rs = 5'd9; rt = 5'd9;
        do_cycle();
        chk("hazard_rd1", readdat1, BYPASS ? 32'h22 : 32'h11);
        chk("hazard_rd2", readdat2, BYPASS ? 32'h22 : 32'h11);
        clear_inputs();
        rs = 5'd9;
        do_cycle();
        chk("hazard_after", readdat1, 32'h22);

        // pass-through fields
        clear_inputs();
        id_npc = 32'h0000_0004; instr_2016 = 5'd5; instr_1511 = 5'd10;
        do_cycle();
        chk("pt_npc", ex_npc, 32'h4);
        chk("pt_2016", {27'd0, ex_instr_2016}, 32'd5);
        chk("pt_1511", {27'd0, ex_instr_1511}, 32'd10);

        // random traffic, reads biased toward recently written registers
        for (int n = 0; n < 300; n++) begin
            logic [4:0] last_w;
            last_w = wb_write_reg;
            case ($urandom_range(0, 4))
                0: opcode = 6'b000000;
                1: opcode = 6'b100011;
                2: opcode = 6'b101011;
                3: opcode = 6'b000100;
                default: opcode = 6'($urandom);
            endcase
            id_npc = $urandom; id_instr = 16'($urandom);
            instr_2016 = 5'($urandom); instr_1511 = 5'($urandom);
            wb_regwrite = 1'($urandom);
            wb_write_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wb_write_data = $urandom;
            rs = ($urandom_range(0, 2) == 0) ? wb_write_reg : 5'($urandom);
            rt = ($urandom_range(0, 2) == 0) ? last_w : 5'($urandom);
            do_cycle();
        end

        // mid-cycle reset with nonzero state; a WB write during reset must be dropped
        clear_inputs();
        id_npc = 32'hCAFE_0000; opcode = 6'b100011; rs = 5'd9; id_instr = 16'h8000;
        do_cycle();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        wb_regwrite = 1'b1; wb_write_reg = 5'd7; wb_write_data = 32'h7777_7777;
        @(posedge clk); #1;
        chk_all_zero("mid_rst_edge");
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        clear_inputs();
        #1;
        chk_all_zero("post_rel");
        for (int i = 1; i < 32; i++) begin
            clear_inputs();
            rs = 5'(i); rt = 5'(i);
            do_cycle();
            chk($sformatf("rst_r%0d", i), readdat1 | readdat2, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
